jtag_debug_cmd_sync: RTL and testbench
======================================

Name: jtag_debug_cmd_sync

Overview:
System-clock side of the debug-module JTAG path, generalised from the fixed 2-bit-IR / 38-bit variant.
- Synchronises update-DR and update-IR events from the TCK domain, which arrive as toggle signals.
- Captures the TCK shift register and IR into a parametrised command FIFO.
- Presents commands on a valid/ready handshake, with one-hot take_action / take_no_action pulses per IR channel.
- Sits between the virtual-JTAG TCK logic and the OCI break/mem/trace controllers.

Parameters:
SR_WIDTH, 38, width of captured shift register and cmd_data
IR_WIDTH, 2, IR width; channel count NCH = 2**IR_WIDTH
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
SYNC_STAGES, 2, synchroniser flops per toggle input (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
udr_tgl  in  1  TCK-domain toggle, flips once per update-DR
uir_tgl  in  1  TCK-domain toggle, flips once per update-IR
sr  in  SR_WIDTH  TCK shift register, stable while udr_tgl is unsynchronised
ir_in  in  IR_WIDTH  current IR, stable under the same rule
cmd_ready  in  1  consumer accepts head command
overflow_clr  in  1  clears overflow sticky
cmd_valid  out  1  FIFO non-empty
cmd_ir  out  IR_WIDTH  head command IR
cmd_data  out  SR_WIDTH  head command data (jdo)
take_action  out  NCH  one-hot pulse: command accepted with data MSB=1
take_no_action  out  NCH  one-hot pulse: command accepted with data MSB=0
uir_pulse  out  1  one-cycle pulse per update-IR event
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: a command was dropped

Behaviour:
- Reset (async assert, synchronous release): every output is 0, synchroniser chains are 0, FIFO is empty, and armed=0.
- Synchroniser: each toggle passes through SYNC_STAGES flops plus one history flop. The event is the XOR of the last stage and the history flop.
- Arming: armed sets SYNC_STAGES+1 cycles after reset release. Events are suppressed while armed=0, so a toggle level of 1 at reset release creates no spurious event.
- udr event, FIFO not full: {ir_in, sr} is written on the same edge.
- udr event, FIFO full and no pop this cycle: the write is dropped and overflow sets.
- Full with simultaneous pop: the write is accepted.
- Latency, empty FIFO: cmd_valid rises on edge SYNC_STAGES+2 after the first edge that samples the new udr_tgl level.
- FIFO is show-ahead: cmd_ir and cmd_data show the head entry whenever cmd_valid=1. They hold their last value when empty and are never X after reset.
- Transfer occurs when cmd_valid & cmd_ready. The head pops on that edge.
- On the edge after a transfer, take_action[ir] pulses high for 1 cycle if data[SR_WIDTH-1]=1; otherwise take_no_action[ir] pulses. Exactly one bit of the two vectors is high per transfer, and none otherwise.
- Back-to-back transfers produce back-to-back pulses.
- Push and pop on the same edge: fifo_count is unchanged, ordering is preserved, and pointers wrap modulo FIFO_DEPTH.
- cmd_ready while empty has no effect and no pulse.
- uir event: uir_pulse is high for 1 cycle. FIFO contents are unaffected; queued commands keep the IR captured at their udr.
- udr and uir events in the same cycle: both are processed independently.
- overflow_clr and a new drop in the same cycle: the drop wins (overflow stays 1).
- Consecutive udr toggles closer than SYNC_STAGES+1 clk cycles are outside protocol. The TCK side guarantees the spacing; behaviour is undefined.
- Reset asserted mid-operation: the FIFO is discarded, all pulses stop immediately, and re-arming follows release.

Test Plan:
1. Reset with udr_tgl=1 held, release, wait 10 cycles -> cmd_valid=0, fifo_count=0, no take_* pulse.
2. Defaults. ir_in=2'b01, sr=38'h20_0000_1234, toggle udr_tgl, cmd_ready=1 -> cmd_valid rises 4 edges after sampling, cmd_data=38'h20_0000_1234, then take_action=4'b0010 for exactly 1 cycle.
3. Same command with sr MSB=0 and ir_in=2'b11 -> take_no_action=4'b1000 pulse; take_action stays 0.
4. cmd_ready=0, issue 5 udr events spaced 4 cycles apart (sr=1..5) -> fifo_count=4 and overflow=1. Then cmd_ready=1 -> data 1,2,3,4 delivered in order, and 5 is lost.
5. FIFO full, udr event on the same cycle as a pop -> count stays 4, overflow stays 0, new entry delivered last. Next, overflow_clr coincident with a drop -> overflow=1.
6. Toggle uir_tgl and udr_tgl on the same cycle -> uir_pulse for 1 cycle and one FIFO entry. Assert reset_n=0 while 2 entries are queued -> outputs 0 immediately, empty after release.

Source files
------------

// File: rtl/jtag_debug_cmd_sync.sv
// System-clock side of the debug JTAG path: synchronises TCK-domain update toggles,
// queues {ir, sr} commands in a show-ahead FIFO and issues per-channel take pulses.
module jtag_debug_cmd_sync #(
  parameter  int SR_WIDTH    = 38,
  parameter  int IR_WIDTH    = 2,
  parameter  int FIFO_DEPTH  = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int NCH         = 2 ** IR_WIDTH,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                udr_tgl,
  input  logic                uir_tgl,
  input  logic [SR_WIDTH-1:0] sr,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic                cmd_ready,
  input  logic                overflow_clr,
  output logic                cmd_valid,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [SR_WIDTH-1:0] cmd_data,
  output logic [NCH-1:0]      take_action,
  output logic [NCH-1:0]      take_no_action,
  output logic                uir_pulse,
  output logic [CW-1:0]       fifo_count,
  output logic                overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = IR_WIDTH + SR_WIDTH;
  localparam int ACW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d;
  logic                   udr_hist_q, udr_hist_d, uir_hist_q, uir_hist_d;
  logic [ACW-1:0]         arm_cnt_q, arm_cnt_d;
  logic                   armed_q, armed_d;
  logic                   udr_evt_q, udr_evt_d, udr_wr_q, udr_wr_d;
  logic [EW-1:0]          cap_q, cap_d;
  logic [EW-1:0]          head_q, head_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [NCH-1:0]         take_action_q, take_action_d, take_no_action_q, take_no_action_d;
  logic                   uir_pulse_q, uir_pulse_d;
  logic                   overflow_q, overflow_d;
  logic [NCH-1:0]         ir_sel;
  logic                   udr_evt, uir_evt, full, pop, push, drop;

  logic [EW-1:0] mem [FIFO_DEPTH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ir_sel
      assign ir_sel[gi] = (cmd_ir == IR_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], udr_tgl};
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], uir_tgl};
    udr_hist_d = udr_sync_q[SYNC_STAGES-1];
    uir_hist_d = uir_sync_q[SYNC_STAGES-1];
    // History keeps tracking while unarmed so a toggle level present at release is absorbed.
    armed_d    = armed_q | (arm_cnt_q == ACW'(SYNC_STAGES));
    arm_cnt_d  = armed_q ? arm_cnt_q : arm_cnt_q + ACW'(1);
    udr_evt    = armed_q & (udr_sync_q[SYNC_STAGES-1] ^ udr_hist_q);
    uir_evt    = armed_q & (uir_sync_q[SYNC_STAGES-1] ^ uir_hist_q);

    // The command is captured as soon as the event is seen, then retimed once before the write.
    udr_evt_d  = udr_evt;
    udr_wr_d   = udr_evt_q;
    cap_d      = udr_evt ? {ir_in, sr} : cap_q;
    uir_pulse_d = uir_evt;

    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = (count_q != '0) & cmd_ready;
    push     = udr_wr_q & (~full | pop);
    drop     = udr_wr_q & full & ~pop;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    // Head register: bypass the incoming entry when it becomes the only one held.
    head_d = head_q;
    if ((count_d != '0) && (pop || (count_q == '0))) begin
      head_d = (count_q == CW'(pop)) ? cap_q : mem[rd_ptr_d];
    end

    take_action_d    = (pop &  cmd_data[SR_WIDTH-1]) ? ir_sel : '0;
    take_no_action_d = (pop & ~cmd_data[SR_WIDTH-1]) ? ir_sel : '0;
    overflow_d       = drop | (overflow_q & ~overflow_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q       <= '0;
      uir_sync_q       <= '0;
      udr_hist_q       <= 1'b0;
      uir_hist_q       <= 1'b0;
      arm_cnt_q        <= '0;
      armed_q          <= 1'b0;
      udr_evt_q        <= 1'b0;
      udr_wr_q         <= 1'b0;
      cap_q            <= '0;
      head_q           <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      uir_pulse_q      <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      udr_sync_q       <= udr_sync_d;
      uir_sync_q       <= uir_sync_d;
      udr_hist_q       <= udr_hist_d;
      uir_hist_q       <= uir_hist_d;
      arm_cnt_q        <= arm_cnt_d;
      armed_q          <= armed_d;
      udr_evt_q        <= udr_evt_d;
      udr_wr_q         <= udr_wr_d;
      cap_q            <= cap_d;
      head_q           <= head_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      uir_pulse_q      <= uir_pulse_d;
      overflow_q       <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cap_q;
  end

  assign cmd_valid      = (count_q != '0);
  assign cmd_ir         = head_q[EW-1:SR_WIDTH];
  assign cmd_data       = head_q[SR_WIDTH-1:0];
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign uir_pulse      = uir_pulse_q;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Directed bench for jtag_debug_cmd_sync at default parameters.
module tb_jtag_debug_cmd_sync;

  logic        clk, reset_n, udr_tgl, uir_tgl, cmd_ready, overflow_clr;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        cmd_valid, uir_pulse, overflow;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fifo_count;
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  seen;

  jtag_debug_cmd_sync dut (
    .clk(clk), .reset_n(reset_n), .udr_tgl(udr_tgl), .uir_tgl(uir_tgl),
    .sr(sr), .ir_in(ir_in), .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .take_action(take_action), .take_no_action(take_no_action),
    .uir_pulse(uir_pulse), .fifo_count(fifo_count), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ir, input logic [37:0] d);
    ir_in   = ir;
    sr      = d;
    udr_tgl = ~udr_tgl;
    $display("udr  ir=%0d sr=%0h t=%0t", ir, d, $time);
  endtask

  task automatic fill4(input logic [37:0] base);
    for (int k = 0; k < 4; k++) begin
      send(2'd0, base + 38'(k));
      repeat (4) step();
    end
    repeat (2) step();
  endtask

  initial begin
    reset_n = 1'b0; udr_tgl = 1'b1; uir_tgl = 1'b0;
    sr = '0; ir_in = '0; cmd_ready = 1'b0; overflow_clr = 1'b0;

    // Reset with udr_tgl high, then release: no spurious command.
    repeat (3) step();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_take", {take_action, take_no_action}, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    seen = '0;
    repeat (10) begin
      step();
      seen |= {cmd_valid, take_action, take_no_action};
    end
    chk("arm_no_event", seen, 0);
    chk("arm_count", fifo_count, 0);

    // Latency and take_action on channel 1.
    cmd_ready = 1'b1;
    send(2'd1, 38'h20_0000_1234);
    for (int n = 0; n < 8; n++) begin
      step();
      chk($sformatf("lat_valid_%0d", n), cmd_valid, (n == 4));
      chk($sformatf("lat_ta_%0d", n), take_action, (n == 5) ? 4'b0010 : 4'b0000);
      chk($sformatf("lat_tna_%0d", n), take_no_action, 0);
      if (n == 4) begin
        chk("lat_data", cmd_data, 38'h20_0000_1234);
        chk("lat_ir", cmd_ir, 2'd1);
      end
    end

    // MSB clear on channel 3 -> take_no_action.
    send(2'd3, 38'h00_0000_00ab);
    for (int n = 0; n < 8; n++) begin
      step();
      chk($sformatf("tna_ta_%0d", n), take_action, 0);
      chk($sformatf("tna_tna_%0d", n), take_no_action, (n == 5) ? 4'b1000 : 4'b0000);
    end

    // Overflow: five commands into a four-deep queue.
    cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(2'd2, 38'(k));
      repeat (4) step();
    end
    repeat (4) step();
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", cmd_data, 1);
    cmd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_order_%0d", k), cmd_data, k);
      step();
      chk($sformatf("ovf_pulse_%0d", k), take_no_action, 4'b0100);
      $display("xfer ir=2 data=%0h", k);
    end
    cmd_ready = 1'b0;
    chk("ovf_empty", cmd_valid, 0);
    step();
    chk("ovf_pulse_end", take_no_action, 0);
    chk("ovf_lost", fifo_count, 0);

    // Full queue with a write coinciding with a pop.
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("clr_ovf", overflow, 0);
    fill4(38'h11);
    chk("pp_full", fifo_count, 4);
    send(2'd0, 38'h15);
    repeat (4) step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("pp_count", fifo_count, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", cmd_data, 38'h12);
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pp_order_%0d", k), cmd_data, 38'h12 + 38'(k));
      step();
      $display("xfer ir=0 data=%0h", 38'h12 + 38'(k));
    end
    cmd_ready = 1'b0;
    chk("pp_drained", fifo_count, 0);

    // Overflow clear coincident with a drop: the drop wins.
    fill4(38'h21);
    send(2'd0, 38'h25);
    repeat (4) step();
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("clr_drop_ovf", overflow, 1);
    chk("clr_drop_count", fifo_count, 4);
    chk("clr_drop_head", cmd_data, 38'h21);
    cmd_ready = 1'b1;
    repeat (4) step();
    cmd_ready = 1'b0;
    chk("clr_drop_drained", fifo_count, 0);

    // Simultaneous update-IR and update-DR.
    uir_tgl = ~uir_tgl;
    send(2'd1, 38'h33);
    for (int n = 0; n < 8; n++) begin
      step();
      chk($sformatf("uir_pulse_%0d", n), uir_pulse, (n == 2));
      if (n == 3) ir_in = 2'd2;
    end
    chk("uir_count", fifo_count, 1);
    chk("uir_keep_ir", cmd_ir, 2'd1);
    chk("uir_data", cmd_data, 38'h33);

    // Reset mid-operation with two entries queued.
    send(2'd2, 38'h44);
    repeat (6) step();
    chk("mid_count", fifo_count, 2);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_head", {cmd_ir, cmd_data}, 0);
    chk("mid_rst_pulses", {uir_pulse, take_action, take_no_action}, 0);
    chk("mid_rst_ovf", overflow, 1'b0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_valid", cmd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
